// File: rtl/usb_cmd_pkg.sv
// usb_cmd_pkg
//   Shared constants and types for the USB command framer:
//   - sync header byte values
//   - error code values reported on err_code
//   - parser state enumeration
package usb_cmd_pkg;

  // Two-byte sync header that opens every frame.
  localparam logic [7:0] SYNC0_BYTE = 8'hAA;
  localparam logic [7:0] SYNC1_BYTE = 8'h55;

  // err_code values, qualified by err_pulse.
  localparam logic [1:0] ERR_BUSY    = 2'd0;  // byte dropped while a frame is held
  localparam logic [1:0] ERR_CSUM    = 2'd1;  // checksum mismatch
  localparam logic [1:0] ERR_LEN     = 2'd2;  // length exceeds buffer depth
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;  // inter-byte gap too long

  typedef enum logic [2:0] {
    ST_SYNC0 = 3'd0,
    ST_SYNC1 = 3'd1,
    ST_CMD   = 3'd2,
    ST_LEN   = 3'd3,
    ST_DATA  = 3'd4,
    ST_CSUM  = 3'd5,
    ST_HOLD  = 3'd6
  } parser_state_t;

endpackage

// File: rtl/cmd_payload_ram.sv
// cmd_payload_ram
//   Simple dual-port synchronous RAM holding one frame's payload.
//   One write port driven by the parser, one registered read port.
// Ports:
//   clk    in   clock
//   rst    in   synchronous active-high reset (clears read register only)
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   read address
//   rdata  out  read data, one cycle after raddr
module cmd_payload_ram #(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  // The array itself is never reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Output register reset keeps rd_data at zero after reset while
  // remaining compatible with the RAM primitive's output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= 8'h00;
    end else begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/usb_cmd_parser.sv
// usb_cmd_parser
//   Byte-stream framer: hunts for AA 55, captures CMD, LEN and payload,
//   checks the 8-bit additive checksum and presents validated frames
//   through a valid/ack handshake. Bad, stalled or colliding frames are
//   dropped and reported on err_pulse/err_code.
// Ports:
//   clk                in   clock
//   rst                in   synchronous active-high reset
//   usb_data_in        in   received byte
//   usb_data_valid_in  in   one-cycle strobe per byte
//   cmd_valid          out  validated frame held until cmd_ack
//   cmd_code           out  command byte of held frame
//   cmd_len            out  payload length of held frame
//   cmd_ack            in   downstream done with frame
//   rd_addr            in   payload read address
//   rd_data            out  payload byte, one cycle after rd_addr
//   err_pulse          out  one-cycle error strobe
//   err_code           out  error cause, valid with err_pulse
module usb_cmd_parser
  import usb_cmd_pkg::*;
#(
  parameter int MAX_LEN        = 64,
  parameter int TIMEOUT_CYCLES = 60000,
  parameter int AW             = $clog2(MAX_LEN)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    usb_data_in,
  input  logic          usb_data_valid_in,
  output logic          cmd_valid,
  output logic [7:0]    cmd_code,
  output logic [7:0]    cmd_len,
  input  logic          cmd_ack,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  output logic          err_pulse,
  output logic [1:0]    err_code
);

  localparam int              CW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0]   IDLE_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]      MAX_LEN_B = 8'(MAX_LEN);

  parser_state_t state_reg, state_next;
  logic [7:0]    code_reg, code_next;
  logic [7:0]    len_reg, len_next;
  logic [7:0]    sum_reg, sum_next;
  // 8 bits covers any legal length, so the index never wraps.
  logic [7:0]    idx_reg, idx_next;
  logic [CW-1:0] idle_cnt_reg, idle_cnt_next;
  logic          err_pulse_reg, err_pulse_next;
  logic [1:0]    err_code_reg, err_code_next;

  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [7:0]    ram_wdata;
  logic          counting;

  // Idle timer only runs while a frame is partially received.
  assign counting = (state_reg != ST_SYNC0) && (state_reg != ST_HOLD);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_SYNC0;
      code_reg      <= 8'h00;
      len_reg       <= 8'h00;
      sum_reg       <= 8'h00;
      idx_reg       <= 8'h00;
      idle_cnt_reg  <= '0;
      err_pulse_reg <= 1'b0;
      err_code_reg  <= 2'd0;
    end else begin
      state_reg     <= state_next;
      code_reg      <= code_next;
      len_reg       <= len_next;
      sum_reg       <= sum_next;
      idx_reg       <= idx_next;
      idle_cnt_reg  <= idle_cnt_next;
      err_pulse_reg <= err_pulse_next;
      err_code_reg  <= err_code_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    code_next      = code_reg;
    len_next       = len_reg;
    sum_next       = sum_reg;
    idx_next       = idx_reg;
    idle_cnt_next  = '0;
    err_pulse_next = 1'b0;
    err_code_next  = err_code_reg;
    ram_we         = 1'b0;
    ram_waddr      = idx_reg[AW-1:0];
    ram_wdata      = usb_data_in;

    if (usb_data_valid_in) begin
      case (state_reg)
        ST_SYNC0: begin
          if (usb_data_in == SYNC0_BYTE) state_next = ST_SYNC1;
        end
        ST_SYNC1: begin
          // A repeated AA may be the real header start, so stay put.
          if (usb_data_in == SYNC1_BYTE)      state_next = ST_CMD;
          else if (usb_data_in != SYNC0_BYTE) state_next = ST_SYNC0;
        end
        ST_CMD: begin
          code_next  = usb_data_in;
          sum_next   = usb_data_in;
          state_next = ST_LEN;
        end
        ST_LEN: begin
          len_next = usb_data_in;
          sum_next = sum_reg + usb_data_in;
          idx_next = 8'h00;
          if (usb_data_in == 8'h00) begin
            state_next = ST_CSUM;
          end else if (usb_data_in > MAX_LEN_B) begin
            state_next     = ST_SYNC0;
            err_pulse_next = 1'b1;
            err_code_next  = ERR_LEN;
          end else begin
            state_next = ST_DATA;
          end
        end
        ST_DATA: begin
          ram_we   = 1'b1;
          sum_next = sum_reg + usb_data_in;
          idx_next = idx_reg + 8'd1;
          if (idx_reg + 8'd1 == len_reg) state_next = ST_CSUM;
        end
        ST_CSUM: begin
          if (usb_data_in == sum_reg) begin
            state_next = ST_HOLD;
          end else begin
            state_next     = ST_SYNC0;
            err_pulse_next = 1'b1;
            err_code_next  = ERR_CSUM;
          end
        end
        ST_HOLD: begin
          // Buffer is owned by the consumer; drop the byte and say so.
          err_pulse_next = 1'b1;
          err_code_next  = ERR_BUSY;
        end
        default: state_next = ST_SYNC0;
      endcase
    end else if (counting) begin
      if (idle_cnt_reg == IDLE_LAST) begin
        state_next     = ST_SYNC0;
        err_pulse_next = 1'b1;
        err_code_next  = ERR_TIMEOUT;
      end else begin
        idle_cnt_next = idle_cnt_reg + 1'b1;
      end
    end

    // Ack releases the held frame even if a colliding byte arrives.
    if (state_reg == ST_HOLD && cmd_ack) state_next = ST_SYNC0;
  end

  cmd_payload_ram #(
    .DEPTH (MAX_LEN),
    .AW    (AW)
  ) u_payload_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  assign cmd_valid = (state_reg == ST_HOLD);
  assign cmd_code  = code_reg;
  assign cmd_len   = len_reg;
  assign err_pulse = err_pulse_reg;
  assign err_code  = err_code_reg;

endmodule
